// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC source
// encodings and the fetch FSM state type.
package fetch_unit_pkg;

    // Next-PC source selected by the controller on the writeback strobe.
    localparam logic [1:0] PC_4     = 2'b00;
    localparam logic [1:0] PC_14BIT = 2'b01;
    localparam logic [1:0] PC_24BIT = 2'b10;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port.
// Handshake: the master raises im_req with a stable im_addr and keeps both
// until the slave answers with im_ready; a transfer happens on each clock
// edge where im_req && im_ready, and im_rdata is valid in that cycle only.
// im_ready while im_req is low carries no meaning.
interface fetch_unit_if #(
    parameter int PC_WIDTH = 32
) ();
    logic                im_req;
    logic [PC_WIDTH-1:0] im_addr;
    logic                im_ready;
    logic [31:0]         im_rdata;

    modport master (output im_req, output im_addr, input im_ready, input im_rdata);
    modport slave  (input im_req, input im_addr, output im_ready, output im_rdata);
endinterface

// File: rtl/fetch_unit_pc_next_gen.sv
// Combinational next-PC generator: PC+4, or PC plus a signed halfword
// displacement taken from the 14-bit branch or 24-bit jump immediate.
module fetch_unit_pc_next_gen
    import fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic [1:0]          i_select_pc,
    input  logic [13:0]         i_imm_14bit,
    input  logic [23:0]         i_imm_24bit,
    output logic [PC_WIDTH-1:0] o_next_pc
);

    logic [PC_WIDTH-1:0] w_disp_14;
    logic [PC_WIDTH-1:0] w_disp_24;

    // Displacements are in halfwords: sign-extend, then shift left by one.
    assign w_disp_14 = {{(PC_WIDTH-15){i_imm_14bit[13]}}, i_imm_14bit, 1'b0};
    assign w_disp_24 = {{(PC_WIDTH-25){i_imm_24bit[23]}}, i_imm_24bit, 1'b0};

    // Select the next PC; the unused encoding falls back to sequential flow.
    always_comb begin
        o_next_pc = i_pc + PC_WIDTH'(4);
        case (i_select_pc)
            PC_14BIT: o_next_pc = i_pc + w_disp_14;
            PC_24BIT: o_next_pc = i_pc + w_disp_24;
            default:  o_next_pc = i_pc + PC_WIDTH'(4);
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one memory read per fetch
// strobe and registers the returned word for the controller.
// Optional build macro: FETCH_MISALIGN_CHECK_EN (blocks fetches from an
// unaligned PC and raises a sticky fetch_misalign flag).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable_fetch,
    input  logic                enable_writeback,
    input  logic [1:0]          select_pc,
    input  logic [13:0]         imm_14bit,
    input  logic [23:0]         imm_24bit,
    fetch_unit_if.master        im,
    output logic [31:0]         instruction,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic                fetch_stall,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic                fetch_misalign,
`endif
    output state_t              dbg_state
);

    state_t              r_state;
    state_t              w_state_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_im_addr;
    logic [31:0]         r_instruction;
    logic                r_instr_valid;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic                w_busy;
    logic                w_accept;
    logic                w_fetch_start;
    logic                w_addr_ok;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;
    assign w_addr_ok      = (r_pc[1:0] == 2'b00);
    assign fetch_misalign = r_misalign;
`else
    assign w_addr_ok = 1'b1;
`endif

    assign w_fetch_start = enable_fetch && (r_state == IDLE) && w_addr_ok;
    assign w_busy        = (r_state == REQ) || (r_state == WAIT);
    assign w_accept      = w_busy && im.im_ready;

    fetch_unit_pc_next_gen #(.PC_WIDTH(PC_WIDTH)) u_pc_next_gen (
        .i_pc        (r_pc),
        .i_select_pc (select_pc),
        .i_imm_14bit (imm_14bit),
        .i_imm_24bit (imm_24bit),
        .o_next_pc   (w_next_pc)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // FSM next-state logic; strobes outside IDLE are dropped, not queued.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_fetch_start) w_state_next = REQ;
            REQ:     w_state_next = im.im_ready ? IDLE : WAIT;
            WAIT:    if (im.im_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs, decoded from state so a reset drops im_req at once.
    always_comb begin
        im.im_req   = w_busy;
        fetch_stall = (r_state == WAIT);
    end

    // Request address is latched at fetch start, decoupled from later PC commits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)             r_im_addr <= '0;
        else if (w_fetch_start) r_im_addr <= r_pc;
    end

    // Capture the returned word and pulse instr_valid for one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_instruction <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_instr_valid <= w_accept;
            if (w_accept) r_instruction <= im.im_rdata;
        end
    end

    // Committed PC advances on every writeback strobe, whatever the FSM does.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                r_pc <= RESET_PC;
        else if (enable_writeback) r_pc <= w_next_pc;
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky flag for a fetch attempted from an unaligned PC.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                            r_misalign <= 1'b0;
        else if (enable_fetch && (r_state == IDLE) && !w_addr_ok) r_misalign <= 1'b1;
    end
`endif

    assign im.im_addr  = r_im_addr;
    assign instruction = r_instruction;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a scoreboard of expected
// instruction captures. Inputs change and outputs are sampled on negedge.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clock;
    logic        reset;
    logic        enable_fetch;
    logic        enable_writeback;
    logic [1:0]  select_pc;
    logic [13:0] imm_14bit;
    logic [23:0] imm_24bit;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic        fetch_stall;
    state_t      dbg_state;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] data;

    fetch_unit_if #(.PC_WIDTH(32)) im ();

    fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clock            (clock),
        .reset            (reset),
        .enable_fetch     (enable_fetch),
        .enable_writeback (enable_writeback),
        .select_pc        (select_pc),
        .imm_14bit        (imm_14bit),
        .imm_24bit        (imm_24bit),
        .im               (im),
        .instruction      (instruction),
        .instr_valid      (instr_valid),
        .pc               (pc),
        .fetch_stall      (fetch_stall),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_misalign   (fetch_misalign),
`endif
        .dbg_state        (dbg_state)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Driver: one writeback strobe, then check the committed PC.
    task automatic writeback(input logic [1:0] sel, input logic [13:0] i14,
                             input logic [23:0] i24, input logic [31:0] exp_pc,
                             input string tag);
        enable_writeback = 1'b1;
        select_pc        = sel;
        imm_14bit        = i14;
        imm_24bit        = i24;
        tick();
        enable_writeback = 1'b0;
        check(tag, pc, exp_pc);
    endtask

    // Scoreboard: every capture must match the oldest expected word.
    always @(negedge clock) begin
        if (instr_valid === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_capture", 32'd1, 32'd0);
            else                   check("sb_instruction", instruction, exp_q.pop_front());
        end
    end

    initial begin
        reset            = 1'b0;
        enable_fetch     = 1'b0;
        enable_writeback = 1'b0;
        select_pc        = PC_4;
        imm_14bit        = '0;
        imm_24bit        = '0;
        im.im_ready      = 1'b0;
        im.im_rdata      = '0;
        tick();
        tick();

        // Reset state
        check("rst_pc",     pc, 32'h0);
        check("rst_req",    32'(im.im_req), 32'd0);
        check("rst_addr",   im.im_addr, 32'h0);
        check("rst_instr",  instruction, 32'h0);
        check("rst_valid",  32'(instr_valid), 32'd0);
        check("rst_stall",  32'(fetch_stall), 32'd0);
        check("rst_state",  32'(dbg_state), 32'(IDLE));
        reset = 1'b1;
        tick();

        // Zero-wait fetch
        im.im_ready  = 1'b1;
        im.im_rdata  = 32'h4A00_0001;
        enable_fetch = 1'b1;
        exp_q.push_back(32'h4A00_0001);
        tick();
        enable_fetch = 1'b0;
        check("zw_req",    32'(im.im_req), 32'd1);
        check("zw_addr",   im.im_addr, 32'h0);
        check("zw_valid0", 32'(instr_valid), 32'd0);
        tick();
        check("zw_req_drop", 32'(im.im_req), 32'd0);
        check("zw_valid",    32'(instr_valid), 32'd1);
        check("zw_instr",    instruction, 32'h4A00_0001);
        tick();
        check("zw_valid_pulse", 32'(instr_valid), 32'd0);
        check("zw_instr_hold",  instruction, 32'h4A00_0001);

        // Fetch with three wait cycles; a strobe during WAIT is ignored
        data         = $urandom;
        im.im_ready  = 1'b0;
        im.im_rdata  = data;
        enable_fetch = 1'b1;
        tick();
        enable_fetch = 1'b0;
        check("ws_req",    32'(im.im_req), 32'd1);
        check("ws_stall0", 32'(fetch_stall), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ws_stall", 32'(fetch_stall), 32'd1);
            check("ws_addr",  im.im_addr, 32'h0);
            check("ws_valid", 32'(instr_valid), 32'd0);
            enable_fetch = (i == 1);
            if (i == 2) begin
                enable_fetch = 1'b0;
                im.im_ready  = 1'b1;
                exp_q.push_back(data);
            end
        end
        tick();
        check("ws_capture", 32'(instr_valid), 32'd1);
        check("ws_instr",   instruction, data);
        check("ws_idle",    32'(fetch_stall), 32'd0);
        tick();
        check("ws_no_second_req", 32'(im.im_req), 32'd0);
        check("ws_valid_pulse",   32'(instr_valid), 32'd0);
        im.im_ready = 1'b0;

        // Next-PC arithmetic around 0x100
        writeback(PC_24BIT, 14'h0,    24'h000080, 32'h0000_0100, "pc_jump_100");
        writeback(PC_4,     14'h0,    24'h0,      32'h0000_0104, "pc_4");
        writeback(PC_24BIT, 14'h0,    24'hFFFFFE, 32'h0000_0100, "pc_jump_neg");
        writeback(PC_14BIT, 14'h3FFE, 24'h0,      32'h0000_00FC, "pc_br_neg2");
        writeback(PC_24BIT, 14'h0,    24'h000002, 32'h0000_0100, "pc_jump_pos2");
        writeback(PC_24BIT, 14'h0,    24'h000010, 32'h0000_0120, "pc_jump_10");
        writeback(2'b11,    14'h1FFF, 24'h7FFFFF, 32'h0000_0124, "pc_sel_11");
        writeback(PC_14BIT, 14'h1FFF, 24'h0,      32'h0000_4122, "pc_br_maxpos");
        writeback(PC_14BIT, 14'h2000, 24'h0,      32'h0000_0122, "pc_br_maxneg");
        writeback(PC_24BIT, 14'h0,    24'h800000, 32'hFF00_0122, "pc_jump_maxneg");
        writeback(PC_24BIT, 14'h0,    24'h7FFFFF, 32'h0000_0120, "pc_wrap");
        writeback(PC_24BIT, 14'h0,    24'h000070, 32'h0000_0200, "pc_jump_200");

        // Same-cycle fetch and writeback: fetch uses the old PC
        data             = $urandom;
        im.im_ready      = 1'b1;
        im.im_rdata      = data;
        enable_fetch     = 1'b1;
        enable_writeback = 1'b1;
        select_pc        = PC_4;
        exp_q.push_back(data);
        tick();
        enable_fetch     = 1'b0;
        enable_writeback = 1'b0;
        check("same_addr", im.im_addr, 32'h0000_0200);
        check("same_pc",   pc, 32'h0000_0204);
        check("same_req",  32'(im.im_req), 32'd1);
        tick();
        check("same_valid", 32'(instr_valid), 32'd1);
        check("same_instr", instruction, data);
        im.im_ready = 1'b0;
        tick();

        // Reset during WAIT aborts the fetch
        im.im_rdata  = $urandom;
        enable_fetch = 1'b1;
        tick();
        enable_fetch = 1'b0;
        tick();
        check("ra_stall", 32'(fetch_stall), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("ra_req_async", 32'(im.im_req), 32'd0);
        check("ra_instr",     instruction, 32'h0);
        check("ra_pc",        pc, 32'h0);
        check("ra_stall_clr", 32'(fetch_stall), 32'd0);
        im.im_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("ra_no_capture", 32'(instr_valid), 32'd0);
        check("ra_no_req",     32'(im.im_req), 32'd0);
        check("ra_instr_hold", instruction, 32'h0);

        // Fetch from an unaligned PC
        writeback(PC_24BIT, 14'h0, 24'h000081, 32'h0000_0102, "pc_misalign");
        data         = $urandom;
        im.im_rdata  = data;
        enable_fetch = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
        tick();
        enable_fetch = 1'b0;
        check("mis_no_req", 32'(im.im_req), 32'd0);
        check("mis_flag",   32'(fetch_misalign), 32'd1);
        check("mis_state",  32'(dbg_state), 32'(IDLE));
        tick();
        check("mis_no_valid", 32'(instr_valid), 32'd0);
        check("mis_instr",    instruction, 32'h0);
        writeback(PC_4, 14'h0, 24'h0, 32'h0000_0106, "mis_pc4");
        check("mis_sticky", 32'(fetch_misalign), 32'd1);
        reset = 1'b0;
        tick();
        check("mis_rst_clr", 32'(fetch_misalign), 32'd0);
        reset = 1'b1;
        tick();
`else
        exp_q.push_back(data);
        tick();
        enable_fetch = 1'b0;
        check("ua_req",  32'(im.im_req), 32'd1);
        check("ua_addr", im.im_addr, 32'h0000_0102);
        tick();
        check("ua_valid", 32'(instr_valid), 32'd1);
        check("ua_instr", instruction, data);
        tick();
`endif
        im.im_ready = 1'b0;
        tick();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the multi-cycle controller. It owns the program counter and issues one instruction-memory read per fetch strobe through a req/ready handshake. It registers the returned word as the `instruction` bus that the controller decodes. It applies the controller's `select_pc` decision on the writeback strobe to compute the next PC (PC+4, 14-bit branch or 24-bit jump).

Parameters:
PC_WIDTH, 32, width of PC and im_addr
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clock  input  1  single system clock, all state on posedge
reset  input  1  asynchronous, active-low; 0 = reset asserted
enable_fetch  input  1  controller S0 strobe: start a fetch at current pc
enable_writeback  input  1  controller S4 strobe: commit next pc
select_pc  input  2  next-PC source: PC_4 / PC_14BIT / PC_24BIT
imm_14bit  input  14  branch displacement (halfwords, signed)
imm_24bit  input  24  jump displacement (halfwords, signed)
im_req  output  1  instruction-memory read request
im_addr  output  PC_WIDTH  read address, held stable while im_req=1
im_ready  input  1  memory accepts request and returns data this cycle
im_rdata  input  32  instruction word, valid when im_req&&im_ready
instruction  output  32  registered instruction to controller/decoder
instr_valid  output  1  one-cycle pulse when instruction updates
pc  output  PC_WIDTH  current committed PC
fetch_stall  output  1  high while a fetch is outstanding (WAIT state)

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC, im_addr=0, im_req=0, instruction=0, instr_valid=0, fetch_stall=0, state=IDLE. A reset mid-fetch aborts it; im_req drops immediately and no data is captured.
- FSM states:
  - IDLE: im_req=0, fetch_stall=0. On enable_fetch, latch im_addr<=pc and go to REQ.
  - REQ: im_req=1. If im_ready, capture data and go to IDLE. Otherwise go to WAIT.
  - WAIT: im_req=1, fetch_stall=1, im_addr held. Stay until im_ready, then capture and go to IDLE.
- Capture: instruction<=im_rdata and instr_valid=1 for exactly the cycle after the accepting edge. instruction holds its value at all other times.
- Latency: zero-wait memory delivers instruction 2 clocks after the enable_fetch edge (IDLE→REQ, REQ accept). Each wait cycle adds 1.
- enable_fetch while in REQ/WAIT is ignored; no queueing, no second request.
- Next-PC arithmetic (all modulo 2^PC_WIDTH, relative to the committed pc):
  - PC_4: pc+4
  - PC_14BIT: pc + (sign_extend(imm_14bit)<<1)
  - PC_24BIT: pc + (sign_extend(imm_24bit)<<1)
  - Any other select_pc value (2'b11): pc+4
- pc<=next_pc on each enable_writeback, independent of FSM state. im_addr is latched separately, so an outstanding fetch is unaffected.
- enable_fetch and enable_writeback in the same cycle: the fetch latches the old pc and pc updates to next_pc.
- PC wrap-around at 2^PC_WIDTH is silent; no flag.
- im_ready while im_req=0 is ignored.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined: adds output fetch_misalign (1 bit, reset 0). On enable_fetch with pc[1:0]!=0, no request is issued and the FSM stays IDLE. fetch_misalign is set sticky and clears only on reset. instruction holds its value and instr_valid does not pulse.
- Undefined: port absent. Addresses are issued unchecked and im_addr[1:0] passes through.

Decomposition:
- Shared package/header def_muxs additions:
  - select_pc encodings PC_4=2'b00, PC_14BIT=2'b01, PC_24BIT=2'b10.
  - FSM state constants IDLE/REQ/WAIT.
- One natural sub-module: pc_next_gen, the combinational adder/mux producing next_pc from pc, select_pc and the immediates. The FSM and PC register stay in fetch_unit.

Test Plan:
- Reset release, RESET_PC=0, im_ready tied 1, enable_fetch pulse, im_rdata=32'h4A00_0001 → im_req=1 for one cycle with im_addr=0; instruction=32'h4A00_0001 and instr_valid pulses 2 clocks after the strobe.
- im_ready low for 3 cycles → fetch_stall=1 for 3 cycles, im_addr stable, a single capture on the ready cycle, extra enable_fetch pulses during WAIT ignored.
- pc=0x100:
  - PC_4 on writeback → pc=0x104.
  - PC_14BIT with imm_14bit=14'h3FFE (−2) → pc=0x0FC.
  - PC_24BIT with imm_24bit=24'h000010 → pc=0x120.
- Same-cycle enable_fetch and enable_writeback at pc=0x200 with PC_4 → im_addr=0x200, pc=0x204.
- reset driven 0 in WAIT → im_req falls asynchronously, instruction=0, pc=RESET_PC, and no capture when im_ready arrives.
- FETCH_MISALIGN_CHECK_EN defined, pc forced to 0x102 via a branch, enable_fetch → im_req stays 0, fetch_misalign=1 and stays 1 until reset.
